sector_stream_reader: RTL and testbench

- Read-side engine for the 512-byte sector dual-port buffer.
- Once the SD/sector loader has filled a sector through port A, this block drives port B. It sequentially fetches all bytes of the sector and presents them as a valid/ready byte stream to the consuming core logic (FDC/ACSI DMA).
- It hides the one-cycle RAM read latency behind a 2-entry prefetch buffer, so one byte can be delivered per clock.

---
 rtl/sector_stream_reader.sv | 140 ++++++++++++++
 tb/tb_sector_stream_reader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sector_stream_reader.sv
// Sector buffer port-B reader: streams one sector as valid/ready bytes.
// Optional running byte sum output enabled by SECTOR_STREAM_SUM_EN.
module sector_stream_reader #(
  parameter int SECTOR_BYTES = 512,
  parameter int ADDR_W       = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  output logic              ram_oce,
  input  logic [7:0]        ram_dout,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] byte_idx
`ifdef SECTOR_STREAM_SUM_EN
  ,
  output logic [15:0]       sum
`endif
);

  localparam logic [ADDR_W:0] SB_C = (ADDR_W+1)'(SECTOR_BYTES);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(SECTOR_BYTES - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

  state_t          state;
  logic [ADDR_W:0] issued;
  logic [ADDR_W:0] delivered;
  logic [7:0]      fifo_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      count;
  logic            rd_q;
  logic            streaming;
  logic            pop;
  logic            push;
  logic [1:0]      credit;

  assign streaming = (state == STREAM);
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign byte_idx  = delivered[ADDR_W-1:0];
  assign ram_addr  = issued[ADDR_W-1:0];
  assign ram_oce   = busy;

  // Handshake and fetch credit; abort wins over a same-cycle pop.
  always_comb begin
    pop    = streaming && out_valid && out_ready && !abort;
    push   = streaming && rd_q;
    credit = count + {1'b0, rd_q} - {1'b0, pop};
    ram_ce = streaming && (issued < SB_C) && (credit < 2'd2);
  end

  // Control FSM plus prefetch FIFO and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      issued      <= '0;
      delivered   <= '0;
      fifo_mem[0] <= 8'h00;
      fifo_mem[1] <= 8'h00;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      rd_q        <= 1'b0;
`ifdef SECTOR_STREAM_SUM_EN
      sum         <= 16'h0000;
`endif
    end else begin
      done <= 1'b0;
      rd_q <= ram_ce;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= STREAM;
            busy      <= 1'b1;
            issued    <= '0;
            delivered <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
`ifdef SECTOR_STREAM_SUM_EN
            sum       <= 16'h0000;
`endif
          end
        end
        STREAM: begin
          if (abort) begin
            state  <= FLUSH;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
          end else begin
            if (ram_ce)
              issued <= issued + ONE;
            if (push) begin
              fifo_mem[wr_ptr] <= ram_dout;
              wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
              rd_ptr    <= ~rd_ptr;
              delivered <= delivered + ONE;
`ifdef SECTOR_STREAM_SUM_EN
              sum <= sum + {8'h00, out_data};
`endif
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (pop && delivered == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        FLUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sector_stream_reader.sv
// Scoreboard bench for sector_stream_reader.
// Checks sum too when SECTOR_STREAM_SUM_EN is defined.
module tb_sector_stream_reader;

  localparam int SB = 512;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [8:0] ram_addr;
  logic       ram_ce;
  logic       ram_oce;
  logic [7:0] ram_dout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] byte_idx;
`ifdef SECTOR_STREAM_SUM_EN
  logic [15:0] sum;
`endif

  sector_stream_reader #(
    .SECTOR_BYTES(SB),
    .ADDR_W(9)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .abort(abort),
    .busy(busy),
    .done(done),
    .ram_addr(ram_addr),
    .ram_ce(ram_ce),
    .ram_oce(ram_oce),
    .ram_dout(ram_dout),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .byte_idx(byte_idx)
`ifdef SECTOR_STREAM_SUM_EN
    ,
    .sum(sum)
`endif
  );

  logic [7:0]  mem [SB];
  logic [16:0] q[$];
  int checks = 0;
  int passes = 0;
  int beats = 0;
  int strobes = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_hs = 0;
  int rmode = 0;
  int stall_left = 0;
  logic       have_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [8:0] prev_idx = 9'h000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (ram_ce) ram_dout <= mem[ram_addr];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  function automatic logic [15:0] exp_sum();
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < SB; i++) s = s + {8'h00, mem[i]};
    return s;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (beats >= 509 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else out_ready = 1'b1;
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (!reset_n) begin
      beats = 0;
      strobes = 0;
      have_stall = 1'b0;
    end else begin
      if (start && !busy && !abort) begin
        beats = 0;
        strobes = 0;
      end
      if (busy) chk("outstanding_le2", 32'(strobes - beats <= 2), 1);
      if (ram_ce) begin
        chk("ram_addr", 32'(ram_addr), strobes);
        chk("ce_in_range", 32'(strobes < SB), 1);
        strobes++;
      end
      if (have_stall && out_valid) begin
        chk("hold_data", 32'(out_data), 32'(prev_data));
        chk("hold_idx", 32'(byte_idx), 32'(prev_idx));
      end
      if (out_valid && out_ready && !abort) begin
        if (q.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e[7:0]));
          chk("beat_idx", 32'(byte_idx), 32'(e[16:8]));
        end
        beats++;
        last_hs = cyc;
      end
      have_stall = out_valid && !out_ready && !abort;
      prev_data = out_data;
      prev_idx = byte_idx;
      if (done) begin
        done_cnt++;
        chk("done_after_last", 32'(cyc - last_hs), 1);
        chk("done_q_empty", 32'(q.size()), 0);
        chk("done_beats", 32'(beats), SB);
        chk("done_strobes", 32'(strobes), SB);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    for (int i = 0; i < SB; i++) q.push_back({9'(i), mem[i]});
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_in_time", 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_beats(int k, int budget);
    int n = 0;
    while (beats < k && n < budget) begin
      tick();
      n++;
    end
    chk("beats_in_time", 32'(beats >= k), 1);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ce"}, 32'(ram_ce), 0);
    chk({tag, "_oce"}, 32'(ram_oce), 0);
    chk({tag, "_addr"}, 32'(ram_addr), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_idx"}, 32'(byte_idx), 0);
`ifdef SECTOR_STREAM_SUM_EN
    chk({tag, "_sum"}, 32'(sum), 0);
`endif
  endtask

  initial begin
    int d0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < SB; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick();

    // full-speed sector, byte[i] = i
    for (int i = 0; i < SB; i++) q.push_back({9'(i), mem[i]});
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk) chk("lat_c1", 32'(out_valid), 0);
    chk("busy_after_start", 32'(busy), 1);
    @(negedge clk) chk("lat_c2", 32'(out_valid), 0);
    @(negedge clk) chk("lat_c3", 32'(out_valid), 1);
    chk("lat_idx", 32'(byte_idx), 0);
    repeat (SB) @(negedge clk);
    chk("full_done", 32'(done), 1);
    chk("full_busy_low", 32'(busy), 0);
`ifdef SECTOR_STREAM_SUM_EN
    chk("full_sum", 32'(sum), 32'h0000ff00);
`endif
    tick();
    chk("done_one_cycle", 32'(done), 0);

    // random backpressure
    for (int i = 0; i < SB; i++) mem[i] = 8'(i * 7 + 3);
    rmode = 1;
    do_start();
    wait_done(4000);
    rmode = 0;
`ifdef SECTOR_STREAM_SUM_EN
    chk("rand_sum", 32'(sum), 32'(exp_sum()));
`endif
    repeat (3) tick();

    // stall near the end of the sector
    stall_left = 20;
    rmode = 2;
    do_start();
    wait_beats(509, 2000);
    repeat (10) tick();
    chk("stall_valid", 32'(out_valid), 1);
    chk("stall_idx", 32'(byte_idx), 509);
    chk("stall_no_done", 32'(busy), 1);
    wait_done(200);
    rmode = 0;
    repeat (3) tick();

    // abort mid-sector, then restart
    do_start();
    wait_beats(100, 400);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    q.delete();
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_ce", 32'(ram_ce), 0);
    chk("abort_busy_flush", 32'(busy), 1);
    tick();
    chk("abort_busy_low", 32'(busy), 0);
    repeat (5) tick();
    chk("abort_no_done", 32'(done_cnt), 32'(d0));
    do_start();
    wait_done(1000);
    repeat (3) tick();

    // start while busy is ignored
    d0 = done_cnt;
    do_start();
    wait_beats(50, 300);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sb_busy", 32'(busy), 1);
    wait_done(1000);
    repeat (5) tick();
    chk("sb_single_done", 32'(done_cnt), 32'(d0 + 1));

    // async reset mid-transfer
    d0 = done_cnt;
    do_start();
    wait_beats(200, 400);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_ce", 32'(ram_ce), 0);
    chk("idle_no_done", 32'(done_cnt), 32'(d0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
